// File: rtl/pong_video_pkg.sv
// rtl/pong_video_pkg.sv - video timing constants and vblank scheduler state encoding
package pong_video_pkg;

    parameter int TOTAL_COLS  = 800;
    parameter int TOTAL_ROWS  = 525;
    parameter int ACTIVE_ROWS = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/pong_vblank_scheduler_if.sv
// rtl/pong_vblank_scheduler_if.sv - req/done/grant handshake between scheduler and game-object updaters
interface pong_vblank_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] grant;

    modport master (
        input  req,
        input  done,
        output grant
    );

    modport slave (
        output req,
        output done,
        input  grant
    );
endinterface

// File: rtl/vga_frame_event_detect.sv
// rtl/vga_frame_event_detect.sv - decodes vblank start and last pixel of frame from the position counters
module vga_frame_event_detect #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_ROWS = 480
) (
    input  logic [9:0] column_count,
    input  logic [9:0] row_count,
    output logic       vbl_start,
    output logic       frame_end
);
    localparam logic [9:0] VBL_ROW  = 10'(ACTIVE_ROWS);
    localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);

    assign vbl_start = (row_count == VBL_ROW) && (column_count == 10'd0);
    assign frame_end = (row_count == LAST_ROW) && (column_count == LAST_COL);
endmodule

// File: rtl/pong_vblank_scheduler.sv
// rtl/pong_vblank_scheduler.sv - per-frame fixed-priority update-slot scheduler; optional SLOT_TIMEOUT_EN watchdog
module pong_vblank_scheduler
    import pong_video_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TOTAL_COLS  = pong_video_pkg::TOTAL_COLS,
    parameter int TOTAL_ROWS  = pong_video_pkg::TOTAL_ROWS,
    parameter int ACTIVE_ROWS = pong_video_pkg::ACTIVE_ROWS
`ifdef SLOT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [9:0]           column_count,
    input  logic [9:0]           row_count,
    pong_vblank_scheduler_if.master sched_if,
    output logic                 frame_tick,
    output logic                 busy,
    output logic                 overrun,
    output logic [NUM_REQ-1:0]   timed_out
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REQ - 1);

    logic vbl_start;
    logic frame_end;

    vga_frame_event_detect #(
        .TOTAL_COLS  (TOTAL_COLS),
        .TOTAL_ROWS  (TOTAL_ROWS),
        .ACTIVE_ROWS (ACTIVE_ROWS)
    ) u_event_detect (
        .column_count (column_count),
        .row_count    (row_count),
        .vbl_start    (vbl_start),
        .frame_end    (frame_end)
    );

    sched_state_t       state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               frame_tick_q, frame_tick_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               slot_done;

`ifdef SLOT_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]        wd_q, wd_d;
    logic [NUM_REQ-1:0] timed_out_q, timed_out_d;
    logic               wd_expired;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        pending_d    = pending_q;
        grant_d      = grant_q;
        overrun_d    = overrun_q;
        frame_tick_d = vbl_start;
`ifdef SLOT_TIMEOUT_EN
        wd_d        = wd_q;
        timed_out_d = timed_out_q;
        wd_expired  = (wd_q == WD_LIMIT) && !sched_if.done[ptr_q];
        slot_done   = sched_if.done[ptr_q] || wd_expired;
`else
        slot_done   = sched_if.done[ptr_q];
`endif

        // An unfinished sequence is cut off at the last pixel of the frame.
        if (frame_end && (state_q != IDLE)) begin
            grant_d   = '0;
            pending_d = '0;
            overrun_d = 1'b1;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vbl_start) begin
                        pending_d = sched_if.req;
                        ptr_d     = '0;
                        state_d   = SCAN;
                    end
                end
                SCAN: begin
                    if (pending_q[ptr_q]) begin
                        grant_d = NUM_REQ'(1) << ptr_q;
                        state_d = GRANT;
`ifdef SLOT_TIMEOUT_EN
                        wd_d    = '0;
`endif
                    end else if (ptr_q == LAST_PTR) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                GRANT: begin
                    if (slot_done) begin
                        grant_d          = '0;
                        pending_d[ptr_q] = 1'b0;
`ifdef SLOT_TIMEOUT_EN
                        if (wd_expired) begin
                            timed_out_d[ptr_q] = 1'b1;
                        end
`endif
                        if (ptr_q == LAST_PTR) begin
                            state_d = IDLE;
                        end else begin
                            ptr_d   = ptr_q + 1'b1;
                            state_d = SCAN;
                        end
                    end else begin
`ifdef SLOT_TIMEOUT_EN
                        wd_d = wd_q + 16'd1;
`endif
                    end
                end
                default: begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            pending_q    <= '0;
            grant_q      <= '0;
            frame_tick_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SLOT_TIMEOUT_EN
            wd_q         <= '0;
            timed_out_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            frame_tick_q <= frame_tick_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
`ifdef SLOT_TIMEOUT_EN
            wd_q         <= wd_d;
            timed_out_q  <= timed_out_d;
`endif
        end
    end

    assign sched_if.grant = grant_q;
    assign frame_tick     = frame_tick_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;
`ifdef SLOT_TIMEOUT_EN
    assign timed_out      = timed_out_q;
`else
    assign timed_out      = '0;
`endif
endmodule

// File: tb/tb_pong_vblank_scheduler.sv
// tb/tb_pong_vblank_scheduler.sv - directed and randomized frames checked against a slot-timeline model
module tb_pong_vblank_scheduler;
    logic       clock;
    logic       reset;
    logic [9:0] column_count;
    logic [9:0] row_count;
    logic       frame_tick;
    logic       busy;
    logic       overrun;
    logic [3:0] timed_out;

    int errors = 0;
    int checks = 0;

`ifdef SLOT_TIMEOUT_EN
    localparam int TMO = 16;
`endif

    pong_vblank_scheduler_if #(.NUM_REQ(4)) sif ();

    pong_vblank_scheduler #(
        .NUM_REQ (4)
`ifdef SLOT_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TMO)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .column_count (column_count),
        .row_count    (row_count),
        .sched_if     (sif.master),
        .frame_tick   (frame_tick),
        .busy         (busy),
        .overrun      (overrun),
        .timed_out    (timed_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: each index costs one scan cycle, plus its full grant time if pending.
    logic [3:0] exp_grant[$];
    logic [3:0] exp_done[$];
    logic [3:0] exp_tmo_set[$];
    int         lat[4];
    logic       ovr_exp;
    logic [3:0] tmo_exp;

    task automatic build_trace(input logic [3:0] pend);
        exp_grant.delete();
        exp_done.delete();
        exp_tmo_set.delete();
        for (int i = 0; i < 4; i++) begin
            exp_grant.push_back(4'b0);
            exp_done.push_back(4'b0);
            exp_tmo_set.push_back(4'b0);
            if (pend[i]) begin
                int len;
                logic tmo;
                len = lat[i];
                tmo = 1'b0;
`ifdef SLOT_TIMEOUT_EN
                if (len > TMO) begin
                    len = TMO;
                    tmo = 1'b1;
                end
`endif
                for (int j = 1; j <= len; j++) begin
                    exp_grant.push_back(4'b1 << i);
                    exp_done.push_back((j == lat[i]) ? (4'b1 << i) : 4'b0);
                    exp_tmo_set.push_back((tmo && j == len) ? (4'b1 << i) : 4'b0);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] g, input logic b, input logic ft);
        check({tag, " grant"},      32'(sif.grant),  32'(g));
        check({tag, " busy"},       32'(busy),       32'(b));
        check({tag, " frame_tick"}, 32'(frame_tick), 32'(ft));
        check({tag, " overrun"},    32'(overrun),    32'(ovr_exp));
        check({tag, " timed_out"},  32'(timed_out),  32'(tmo_exp));
    endtask

    task automatic drive_neutral();
        row_count    = 10'($urandom_range(0, 523));
        column_count = (row_count == 10'd480) ? 10'($urandom_range(1, 799)) : 10'($urandom_range(0, 799));
        sif.req      = 4'($urandom);
        sif.done     = 4'($urandom);
    endtask

    task automatic run_frame(input logic [3:0] pend, input int cut, input string name);
        int n;
        sif.req      = pend;
        sif.done     = 4'($urandom);
        row_count    = 10'd480;
        column_count = 10'd0;
        step();
        build_trace(pend);
        n = exp_grant.size();
        for (int t = 0; t < n; t++) begin
            check_outputs($sformatf("%s t%0d", name, t), exp_grant[t], 1'b1, (t == 0));
            drive_neutral();
            if (exp_grant[t] != 4'b0) begin
                sif.done = (4'($urandom) & ~exp_grant[t]) | exp_done[t];
            end
            if (t == cut) begin
                row_count    = 10'd524;
                column_count = 10'd799;
            end
            step();
            if (t == cut) begin
                ovr_exp = 1'b1;
                break;
            end
            tmo_exp = tmo_exp | exp_tmo_set[t];
        end
        for (int k = 0; k < 2; k++) begin
            check_outputs($sformatf("%s idle%0d", name, k), 4'b0, 1'b0, 1'b0);
            drive_neutral();
            step();
        end
    endtask

    initial begin
        ovr_exp      = 1'b0;
        tmo_exp      = 4'b0;
        reset        = 1'b1;
        row_count    = 10'd0;
        column_count = 10'd0;
        sif.req      = 4'b0;
        sif.done     = 4'b0;
        step();
        step();
        check_outputs("reset", 4'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drive_neutral();
        step();

        lat = '{1, 3, 2, 4};
        run_frame(4'b0101, -1, "t1_req0101");

        run_frame(4'b0000, -1, "t2_req0000");

        for (int k = 0; k < 12; k++) begin
            drive_neutral();
            row_count = 10'd100;
            step();
            check_outputs($sformatf("t3_mid%0d", k), 4'b0, 1'b0, 1'b0);
        end
        row_count    = 10'd524;
        column_count = 10'd799;
        step();
        check_outputs("t3_frame_end_idle", 4'b0, 1'b0, 1'b0);

        lat = '{1, 1, 1, 10};
        run_frame(4'b1000, 7, "t4_overrun");
        lat = '{2, 1, 3, 1};
        run_frame(4'b1010, -1, "t4_resume");

        lat = '{1, 8, 1, 1};
        sif.req      = 4'b0010;
        sif.done     = 4'b0;
        row_count    = 10'd480;
        column_count = 10'd0;
        step();
        row_count = 10'd200;
        step();
        step();
        check("t5_grant_before_reset", 32'(sif.grant), 32'(4'b0010));
        reset = 1'b1;
        step();
        ovr_exp = 1'b0;
        tmo_exp = 4'b0;
        check_outputs("t5_after_reset", 4'b0, 1'b0, 1'b0);
        reset = 1'b0;
        run_frame(4'b0101, -1, "t5_resume");

`ifdef SLOT_TIMEOUT_EN
        lat = '{100, 3, 1, 1};
        run_frame(4'b0011, -1, "t6_timeout");
`endif

        for (int f = 0; f < 24; f++) begin
            logic [3:0] pend;
            int cut;
            pend = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
`ifdef SLOT_TIMEOUT_EN
                lat[i] = $urandom_range(1, 20);
`else
                lat[i] = $urandom_range(1, 6);
`endif
            end
            build_trace(pend);
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(0, exp_grant.size() - 1) : -1;
            run_frame(pend, cut, $sformatf("rnd%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
